// File: rtl/dii_arb_pkg.sv
// Shared types and constants for the DII packet arbiter.
package dii_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    TERM = 2'd2
  } arb_state_e;

  localparam int DII_WIDTH = 16;

  // Payload of the word that closes a packet abandoned by a stalled module.
  localparam int TERM_WORD = 0;

endpackage

// File: rtl/dii_rr_pick.sv
// Combinational round-robin selector: first requester after ptr_i, wrapping.
module dii_rr_pick #(
  parameter int PORTS = 3,
  parameter int IDXW  = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDXW-1:0]  ptr_i,
  output logic [PORTS-1:0] onehot_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             valid_o
);

  int cand;

  // Walk the scan order backwards so the closest requester after ptr_i wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    for (int k = PORTS; k >= 1; k--) begin
      cand = (int'(ptr_i) + k) % PORTS;
      if (req_i[cand]) begin
        onehot_o       = '0;
        onehot_o[cand] = 1'b1;
        idx_o          = IDXW'(cand);
        valid_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-atomic round-robin merge of PORTS DII channels onto one registered output.
// Optional stall watchdog enabled by defining DII_ARB_WATCHDOG_EN.
module dii_packet_arbiter
  import dii_arb_pkg::*;
#(
  parameter int PORTS   = 3,
  parameter int WIDTH   = DII_WIDTH,
  parameter int TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [PORTS*WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]       in_last,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS-1:0]       in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PORTS-1:0]       grant,
  output logic                   timeout_irq
);

  localparam int IDXW = $clog2(PORTS);

  arb_state_e       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic [PORTS-1:0] drop_q;

  logic             slot_free;
  logic             owner_valid;
  logic             owner_last;
  logic [WIDTH-1:0] owner_data;
  logic             accept;
  logic             load;

  logic [PORTS-1:0] pick_onehot;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_valid;

  dii_rr_pick #(
    .PORTS (PORTS),
    .IDXW  (IDXW)
  ) u_pick (
    .req_i    (in_valid & ~drop_q),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    owner_data = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant_q[p]) owner_data = in_data[p*WIDTH +: WIDTH];
    end
  end

  assign owner_valid = |(in_valid & grant_q);
  assign owner_last  = |(in_last & grant_q);

  // No skid buffer: the owner may only push when the output slot empties this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign accept    = (state_q == PASS) && slot_free && owner_valid;
  assign in_ready  = (((state_q == PASS) && slot_free) ? grant_q : '0) | drop_q;

`ifdef DII_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PORTS-1:0] drop_d;
  logic             irq_q, irq_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      drop_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      irq_q  <= irq_d;
    end
  end

  assign timeout_irq = irq_q;
`else
  assign drop_q      = '0;
  assign timeout_irq = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= IDXW'(PORTS - 1);
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    load       = 1'b0;
`ifdef DII_ARB_WATCHDOG_EN
    cnt_d  = cnt_q;
    irq_d  = 1'b0;
    // A draining port leaves drop mode once its own last word is swallowed.
    drop_d = drop_q & ~(in_valid & in_last);
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          ptr_d   = pick_idx;
          state_d = PASS;
        end
      end

      PASS: begin
        if (accept) begin
          load       = 1'b1;
          out_data_d = owner_data;
          out_last_d = owner_last;
`ifdef DII_ARB_WATCHDOG_EN
          cnt_d      = '0;
`endif
          if (owner_last) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
`ifdef DII_ARB_WATCHDOG_EN
        else if (!owner_valid) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cnt_d   = '0;
            state_d = TERM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end

`ifdef DII_ARB_WATCHDOG_EN
      TERM: begin
        if (slot_free) begin
          load       = 1'b1;
          out_data_d = WIDTH'(TERM_WORD);
          out_last_d = 1'b1;
          irq_d      = 1'b1;
          drop_d     = drop_d | grant_q;
          grant_d    = '0;
          state_d    = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    else out_valid_d = out_valid_q;
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Self-checking bench for dii_packet_arbiter: packet-level reference model plus directed scenarios.
// Watchdog scenario expectations switch on DII_ARB_WATCHDOG_EN.
module tb_dii_packet_arbiter;

  localparam int PORTS   = 3;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [PORTS*WIDTH-1:0] in_data;
  logic [PORTS-1:0]       in_last;
  logic [PORTS-1:0]       in_valid;
  logic [PORTS-1:0]       in_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [PORTS-1:0]       grant;
  logic                   timeout_irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dii_packet_arbiter #(
    .PORTS   (PORTS),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant       (grant),
    .timeout_irq (timeout_irq)
  );

  logic [WIDTH:0]   srcQ[PORTS][$];
  logic [PORTS-1:0] hold;
  logic             readyPat[$];
  logic [WIDTH:0]   outLog[$];
  logic [WIDTH:0]   expLog[$];
  int               irqCount;

  // Reference model: owner index (-1 idle), last winner, pending forced close, output slot.
  int               mOwner   = -1;
  int               mLastWin = PORTS - 1;
  bit               mTerm    = 1'b0;
  logic [PORTS-1:0] mDrop    = '0;
  logic             mValid   = 1'b0;
  logic [WIDTH-1:0] mData    = '0;
  logic             mLastF   = 1'b0;
  logic             mIrq     = 1'b0;
  int               mStall   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mOwner   = -1;
    mLastWin = PORTS - 1;
    mTerm    = 1'b0;
    mDrop    = '0;
    mValid   = 1'b0;
    mData    = '0;
    mLastF   = 1'b0;
    mIrq     = 1'b0;
    mStall   = 0;
  endtask

  function automatic logic [PORTS-1:0] modelReady();
    logic [PORTS-1:0] r;
    r = mDrop;
    if (mOwner >= 0 && !mTerm && (!mValid || out_ready)) r[mOwner] = 1'b1;
    return r;
  endfunction

  function automatic logic [PORTS-1:0] modelGrant();
    logic [PORTS-1:0] g;
    g = '0;
    if (mOwner >= 0) g[mOwner] = 1'b1;
    return g;
  endfunction

  // Advance the model by one clock using the inputs present just before the edge.
  task automatic modelStep();
    logic [PORTS-1:0] oldDrop;
    bit slotFree;
    bit load;
    int p;
    oldDrop  = mDrop;
    slotFree = !mValid || out_ready;
    load     = 1'b0;
    mIrq     = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (oldDrop[i] && in_valid[i] && in_last[i]) mDrop[i] = 1'b0;
    end
    if (mTerm) begin
      if (slotFree) begin
        load          = 1'b1;
        mData         = '0;
        mLastF        = 1'b1;
        mIrq          = 1'b1;
        mDrop[mOwner] = 1'b1;
        mOwner        = -1;
        mTerm         = 1'b0;
      end
    end else if (mOwner < 0) begin
      for (int k = 1; k <= PORTS; k++) begin
        p = (mLastWin + k) % PORTS;
        if (in_valid[p] && !oldDrop[p]) begin
          mOwner   = p;
          mLastWin = p;
          break;
        end
      end
    end else begin
      if (in_valid[mOwner] && slotFree) begin
        load   = 1'b1;
        mData  = in_data[mOwner*WIDTH +: WIDTH];
        mLastF = in_last[mOwner];
        mStall = 0;
        if (in_last[mOwner]) mOwner = -1;
      end
`ifdef DII_ARB_WATCHDOG_EN
      else if (!in_valid[mOwner]) begin
        if (mStall == TIMEOUT - 1) begin
          mTerm  = 1'b1;
          mStall = 0;
        end else begin
          mStall++;
        end
      end
`endif
    end
    if (load) mValid = 1'b1;
    else if (out_ready) mValid = 1'b0;
  endtask

  always @(negedge clk) begin
    checkOutput("grant", 64'(grant), 64'(modelGrant()));
    checkOutput("out_valid", 64'(out_valid), 64'(mValid));
    checkOutput("out_data", 64'(out_data), 64'(mData));
    checkOutput("out_last", 64'(out_last), 64'(mLastF));
    checkOutput("in_ready", 64'(in_ready), 64'(modelReady()));
    checkOutput("timeout_irq", 64'(timeout_irq), 64'(mIrq));
    if (out_valid && out_ready) outLog.push_back({out_last, out_data});
    if (timeout_irq) irqCount++;
  end

  task automatic driveInputs();
    for (int p = 0; p < PORTS; p++) begin
      if (srcQ[p].size() > 0 && !hold[p]) begin
        in_valid[p]                = 1'b1;
        in_data[p*WIDTH +: WIDTH]  = srcQ[p][0][WIDTH-1:0];
        in_last[p]                 = srcQ[p][0][WIDTH];
      end else begin
        in_valid[p]                = 1'b0;
        in_data[p*WIDTH +: WIDTH]  = '0;
        in_last[p]                 = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int p, input logic [WIDTH-1:0] d, input logic last);
    srcQ[p].push_back({last, d});
    driveInputs();
  endtask

  // One clock: note handshakes mid-cycle, step the model on the edge, then drive new inputs.
  task automatic stepCycle();
    logic [PORTS-1:0] fire;
    @(negedge clk);
    fire = in_valid & in_ready;
    @(posedge clk);
    if (rstn) modelStep();
    #1;
    for (int p = 0; p < PORTS; p++) begin
      if (fire[p]) void'(srcQ[p].pop_front());
    end
    out_ready = (readyPat.size() > 0) ? readyPat.pop_front() : 1'b1;
    driveInputs();
  endtask

  task automatic runUntilIdle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      stepCycle();
      done = (srcQ[0].size() == 0) && (srcQ[1].size() == 0) && (srcQ[2].size() == 0)
             && (mOwner < 0) && !mTerm && !mValid;
    end
    checkOutput({name, "_drained"}, 64'(done), 64'd1);
  endtask

  task automatic checkLog(input string name);
    checkOutput({name, "_count"}, 64'(outLog.size()), 64'(expLog.size()));
    for (int i = 0; i < expLog.size() && i < outLog.size(); i++) begin
      checkOutput($sformatf("%s_word%0d", name, i), 64'(outLog[i]), 64'(expLog[i]));
    end
  endtask

  task automatic doReset();
    rstn = 1'b0;
    modelReset();
    for (int p = 0; p < PORTS; p++) srcQ[p].delete();
    hold = '0;
    readyPat.delete();
    out_ready = 1'b1;
    driveInputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    outLog.delete();
    expLog.delete();
  endtask

  initial begin
    int budget;
    rstn      = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    hold      = '0;
    irqCount  = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_irq", 64'(timeout_irq), 64'd0);
    rstn = 1'b1;

    // Single port, three words.
    outLog.delete();
    expLog.delete();
    applyStimulus(1, 16'h1111, 1'b0);
    applyStimulus(1, 16'h2222, 1'b0);
    applyStimulus(1, 16'h3333, 1'b1);
    stepCycle();
    checkOutput("single_grant", 64'(grant), 64'h2);
    checkOutput("single_no_early_valid", 64'(out_valid), 64'd0);
    stepCycle();
    checkOutput("single_first_valid", 64'(out_valid), 64'd1);
    checkOutput("single_first_data", 64'(out_data), 64'h1111);
    runUntilIdle("single", 40);
    checkOutput("single_grant_idle", 64'(grant), 64'd0);
    expLog = '{17'h01111, 17'h02222, 17'h13333};
    checkLog("single");

    // Fairness: every port queues two 2-word packets.
    doReset();
    for (int pkt = 0; pkt < 2; pkt++) begin
      for (int p = 0; p < PORTS; p++) begin
        applyStimulus(p, 16'(p * 16'h1000 + pkt * 16'h10 + 1), 1'b0);
        applyStimulus(p, 16'(p * 16'h1000 + pkt * 16'h10 + 2), 1'b1);
      end
    end
    runUntilIdle("fair", 100);
    expLog = '{17'h00001, 17'h10002, 17'h01001, 17'h11002, 17'h02001, 17'h12002,
               17'h00011, 17'h10012, 17'h01011, 17'h11012, 17'h02011, 17'h12012};
    checkLog("fair");

    // Backpressure mid-packet on port 0.
    outLog.delete();
    expLog.delete();
    applyStimulus(0, 16'hB001, 1'b0);
    applyStimulus(0, 16'hB002, 1'b0);
    applyStimulus(0, 16'hB003, 1'b0);
    applyStimulus(0, 16'hB004, 1'b1);
    stepCycle();
    stepCycle();
    readyPat = '{1'b1, 1'b0, 1'b0, 1'b1};
    stepCycle();
    stepCycle();
    #1;
    checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
    checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
    runUntilIdle("bp", 40);
    expLog = '{17'h0B001, 17'h0B002, 17'h0B003, 17'h1B004};
    checkLog("bp");

    // Reset in the middle of a 4-word packet from port 2.
    applyStimulus(2, 16'h5001, 1'b0);
    applyStimulus(2, 16'h5002, 1'b0);
    applyStimulus(2, 16'h5003, 1'b0);
    applyStimulus(2, 16'h5004, 1'b1);
    budget = 0;
    while (srcQ[2].size() > 2 && budget < 20) begin
      stepCycle();
      budget++;
    end
    checkOutput("mid_two_accepted", 64'(srcQ[2].size()), 64'd2);
    rstn = 1'b0;
    modelReset();
    #1;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_grant", 64'(grant), 64'd0);
    for (int p = 0; p < PORTS; p++) srcQ[p].delete();
    driveInputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    outLog.delete();
    applyStimulus(1, 16'h6001, 1'b1);
    applyStimulus(0, 16'h6000, 1'b1);
    runUntilIdle("mid", 40);
    expLog = '{17'h16000, 17'h16001};
    checkLog("mid");

    // Port 2 sends one word then stalls while port 0 waits.
    outLog.delete();
    irqCount = 0;
    applyStimulus(2, 16'h7001, 1'b0);
    stepCycle();
    stepCycle();
    applyStimulus(0, 16'h7100, 1'b1);
    repeat (14) stepCycle();
`ifdef DII_ARB_WATCHDOG_EN
    checkOutput("wd_irq_pulses", 64'(irqCount), 64'd1);
    checkOutput("wd_grant_released", 64'(grant), 64'd0);
`else
    checkOutput("stall_grant_kept", 64'(grant), 64'h4);
    checkOutput("stall_no_irq", 64'(irqCount), 64'd0);
`endif
    applyStimulus(2, 16'h7002, 1'b0);
    applyStimulus(2, 16'h7003, 1'b1);
    runUntilIdle("stall", 60);
`ifdef DII_ARB_WATCHDOG_EN
    expLog = '{17'h07001, 17'h10000, 17'h17100};
`else
    expLog = '{17'h07001, 17'h07002, 17'h17003, 17'h17100};
`endif
    checkLog("stall");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got no completion, expected finish before 200000");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/dii_packet_arbiter.md
# dii_packet_arbiter

Parametrised, packet-atomic round-robin arbiter merging PORTS debug-interconnect (DII) module channels into one DII output toward the debug ring. It generalises the fixed three-port module/ring attachment of the debug system to any port count and word width. It adds a registered output stage and fair per-packet arbitration. An optional stall watchdog terminates packets from hung modules.

## Interface
- PORTS, 3, number of input DII channels (≥2)
- WIDTH, 16, DII data word width
- TIMEOUT, 256, stall cycles before forced packet termination (watchdog build only, ≥2)

- clk  in  1  single clock
- rstn  in  1  reset, asynchronous, active-low
- in_data  in  PORTS*WIDTH  port i occupies bits [i*WIDTH +: WIDTH]
- in_last  in  PORTS  last word of packet, per port
- in_valid  in  PORTS  word valid, per port
- in_ready  out  PORTS  word accepted when valid&ready
- out_data  out  WIDTH  registered output word
- out_last  out  1  registered last flag
- out_valid  out  1  output word valid
- out_ready  in  1  ring accepts output word
- grant  out  PORTS  one-hot current owner, 0 when idle
- timeout_irq  out  1  one-cycle pulse on forced termination; tied 0 without watchdog

## Operation
- States: IDLE, PASS, TERM (TERM exists only with watchdog).
- IDLE: rr_ptr holds the last granted index. The winner is the first port with in_valid=1 scanning rr_ptr+1 … rr_ptr+PORTS modulo PORTS. Ports in drop mode are excluded. Register grant and rr_ptr := winner, then go to PASS. No input is accepted in IDLE.
- PASS: in_ready[g] = !out_valid | out_ready. Other ports have in_ready=0, except ports in drop mode. An accepted word loads out_data/out_last and sets out_valid. An accepted word with in_last=1 returns the arbiter to IDLE and clears grant.
- Output stage: out_valid clears on out_ready when no new word loads. A simultaneous load and drain keeps out_valid=1.
- Packets are never interleaved. A granted port keeps ownership until its last word is accepted.
- Single-word packets (valid and last in the same word) are legal.
- Reset (asynchronous, any state): state=IDLE, rr_ptr=PORTS-1 so port 0 wins first, grant=0, out_valid=0, out_data=0, out_last=0, in_ready=0, drop flags=0, stall counter=0, timeout_irq=0.

## Timing
- Arbitration costs exactly one IDLE cycle per packet. The first word is accepted the cycle after the request is seen.
- Output latency: 1 cycle from acceptance to out_valid.
- Sustained throughput within a packet: 1 word/cycle when out_ready=1.
- Back-to-back packets: the minimum gap on out_valid is one cycle.
- If out_ready=0, the granted in_ready drops the same cycle (combinational from out_valid/out_ready). No skid buffer is used.

## Configuration
- Macro: DII_ARB_WATCHDOG_EN.
- Defined: in PASS, a stall counter of $clog2(TIMEOUT+1) bits counts cycles with in_valid[g]=0.
  - The counter clears on every accepted word.
  - At count TIMEOUT-1 the arbiter enters TERM.
- TERM:
  - When the output slot is free, load out_data=0 and out_last=1.
  - Pulse timeout_irq in the same cycle.
  - Set drop[g]=1, clear grant, and go to IDLE.
- Drop mode for port p: in_ready[p]=1 and words are discarded. drop[p] clears when a word with in_last=1 is accepted. Port p is excluded from arbitration while in drop mode.
- Not defined: no counter, no TERM, no drop flags. timeout_irq is tied 0. A stalled owner blocks the ring indefinitely.

## Structure
- Package dii_arb_pkg holds:
  - the state enum (IDLE, PASS, TERM)
  - the DII_WIDTH default constant (16)
  - the forced-termination word constant (0)
- Sub-module dii_rr_pick: combinational round-robin selector with PORTS request bits, a rr_ptr input, and one-hot and index outputs. It is instantiated once.
- The top holds the FSM, output register, per-port drop flags and the watchdog counter.

## Test plan
- Single port: port 1 sends 3-word packet 0x1111, 0x2222, 0x3333 (last) with out_ready=1. Expected: out_valid one cycle after each accept, grant=3'b010, return to IDLE, grant=0.
- Fairness: all 3 ports hold 2-word packets continuously after reset. Expected order on output: 0, 1, 2, 0, 1, 2, with one idle cycle between packets and no interleaving.
- Backpressure: out_ready toggles 1, 0, 0, 1 mid-packet. Expected: in_ready[g] follows, no word lost or duplicated, data order preserved.
- Reset mid-packet: deassert rstn after 2 of 4 words. Expected: out_valid=0 and grant=0 immediately. After release, port 0 wins first.
- Watchdog (DII_ARB_WATCHDOG_EN, TIMEOUT=8): port 2 sends 1 word then stalls 8 cycles. Expected: output word 0x0000 with last=1, a one-cycle timeout_irq pulse, then port 0 is granted. Port 2's late words up to its last are drained without appearing on out_data.
- Without the macro: the same stall keeps grant on port 2 indefinitely and timeout_irq stays 0.
